// File: rtl/game_pkg.sv
// Shared encodings for the match controller: one-hot actions, health levels, FSM states, winner codes.
// Pure definitions; no logic, no latency, no flow control.
package game_pkg;

    localparam logic [5:0] ACT_GO_RIGHT = 6'b100000;
    localparam logic [5:0] ACT_GO_LEFT  = 6'b010000;
    localparam logic [5:0] ACT_WAIT     = 6'b001000;
    localparam logic [5:0] ACT_JUMP     = 6'b000100;
    localparam logic [5:0] ACT_KICK     = 6'b000010;
    localparam logic [5:0] ACT_PUNCH    = 6'b000001;

    localparam logic [1:0] ZERO  = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;
    localparam logic [1:0] THREE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COUNTDOWN  = 3'd1,
        ST_FIGHT      = 3'd2,
        ST_ROUND_END  = 3'd3,
        ST_MATCH_OVER = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    function automatic logic is_onehot(input logic [5:0] a);
        return (a != 6'd0) && ((a & (a - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/action_sampler.sv
// Per-player hold register: latches the last clean one-hot action seen during FIGHT.
// Latency 1 cycle; no backpressure. A tick consumes the hold (back to WAIT) unless a new action arrives that cycle.
module action_sampler
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       fight,
    input  logic       tick,
    input  logic [5:0] act,
    output logic [5:0] hold
);

    // A one-hot action on the tick cycle is kept for the following step.
    always_ff @(posedge clk) begin
        if (rst || !fight)
            hold <= ACT_WAIT;
        else if (is_onehot(act))
            hold <= act;
        else if (tick)
            hold <= ACT_WAIT;
    end

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer for a two-player fighting game; issues registered actions on each FIGHT tick.
// Latency: cmd/step one cycle after a FIGHT tick; no backpressure. Optional macro ROUND_TIMEOUT_EN enables round timeout.
module match_controller
    import game_pkg::*;
#(
    parameter int COUNTDOWN_TICKS = 3,
    parameter int ROUND_TICKS     = 30,
    parameter int WINS_TO_MATCH   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tick,
    input  logic [5:0] left_in,
    input  logic [5:0] right_in,
    input  logic [1:0] left_health,
    input  logic [1:0] right_health,
    output logic [5:0] left_cmd,
    output logic [5:0] right_cmd,
    output logic       step,
    output logic       round_rst,
    output logic [2:0] state,
    output logic [1:0] left_wins,
    output logic [1:0] right_wins,
    output logic [5:0] timer,
    output logic [1:0] winner
);

    state_t     state_q, state_nxt;
    logic [7:0] cnt;
    logic [5:0] left_hold, right_hold;
    logic       fight, fight_tick, ko, timeout;
    logic       new_match, go_countdown, end_round;
    logic [1:0] round_res;

    assign state      = state_q;
    assign fight      = (state_q == ST_FIGHT);
    assign fight_tick = fight && tick;
    assign ko         = !step && ((left_health == ZERO) || (right_health == ZERO));
`ifdef ROUND_TIMEOUT_EN
    assign timeout    = (timer == 6'd0);
`else
    assign timeout    = 1'b0;
`endif

    action_sampler u_left  (.clk(clk), .rst(rst), .fight(fight), .tick(tick), .act(left_in),  .hold(left_hold));
    action_sampler u_right (.clk(clk), .rst(rst), .fight(fight), .tick(tick), .act(right_in), .hold(right_hold));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt    = state_q;
        new_match    = 1'b0;
        go_countdown = 1'b0;
        end_round    = 1'b0;
        round_res    = WIN_NONE;
        case (state_q)
            ST_IDLE, ST_MATCH_OVER: begin
                if (start) begin
                    state_nxt    = ST_COUNTDOWN;
                    new_match    = 1'b1;
                    go_countdown = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (tick && cnt == 8'(COUNTDOWN_TICKS - 1))
                    state_nxt = ST_FIGHT;
            end
            ST_FIGHT: begin
                // KO outranks timeout when both happen together.
                if (ko) begin
                    state_nxt = ST_ROUND_END;
                    end_round = 1'b1;
                    if (left_health == ZERO && right_health == ZERO) round_res = WIN_DRAW;
                    else if (right_health == ZERO)                   round_res = WIN_LEFT;
                    else                                             round_res = WIN_RIGHT;
                end else if (timeout) begin
                    state_nxt = ST_ROUND_END;
                    end_round = 1'b1;
                    if (left_health > right_health)      round_res = WIN_LEFT;
                    else if (left_health < right_health) round_res = WIN_RIGHT;
                    else                                 round_res = WIN_DRAW;
                end
            end
            ST_ROUND_END: begin
                if (tick && cnt == 8'd1) begin
                    if (left_wins == 2'(WINS_TO_MATCH) || right_wins == 2'(WINS_TO_MATCH)) begin
                        state_nxt = ST_MATCH_OVER;
                    end else begin
                        state_nxt    = ST_COUNTDOWN;
                        go_countdown = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 8'd0;
            left_cmd   <= ACT_WAIT;
            right_cmd  <= ACT_WAIT;
            step       <= 1'b0;
            round_rst  <= 1'b0;
            left_wins  <= 2'd0;
            right_wins <= 2'd0;
            timer      <= 6'd0;
            winner     <= WIN_NONE;
        end else begin
            round_rst <= go_countdown;
            // A tick that also ends the round is not turned into a step.
            step      <= fight_tick && (state_nxt == ST_FIGHT);

            if (state_nxt != state_q)
                cnt <= 8'd0;
            else if (tick && (state_q == ST_COUNTDOWN || state_q == ST_ROUND_END))
                cnt <= cnt + 8'd1;

            if (state_nxt != ST_FIGHT) begin
                left_cmd  <= ACT_WAIT;
                right_cmd <= ACT_WAIT;
            end else if (fight_tick) begin
                left_cmd  <= left_hold;
                right_cmd <= right_hold;
            end

            if (new_match) begin
                left_wins  <= 2'd0;
                right_wins <= 2'd0;
            end else if (end_round) begin
                if (round_res == WIN_LEFT && left_wins != 2'd3)   left_wins  <= left_wins + 2'd1;
                if (round_res == WIN_RIGHT && right_wins != 2'd3) right_wins <= right_wins + 2'd1;
            end

            if (new_match)
                winner <= WIN_NONE;
            else if (state_q == ST_ROUND_END && state_nxt == ST_MATCH_OVER)
                winner <= (left_wins == 2'(WINS_TO_MATCH)) ? WIN_LEFT : WIN_RIGHT;

            if (new_match)
                timer <= 6'd0;
            else if (state_q == ST_COUNTDOWN && state_nxt == ST_FIGHT)
                timer <= 6'(ROUND_TICKS);
`ifdef ROUND_TIMEOUT_EN
            else if (fight_tick && timer != 6'd0)
                timer <= timer - 6'd1;
`endif
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Scenario bench for match_controller; issued commands are scoreboarded against a queue of expected actions.
module tb_match_controller;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, tick;
    logic [5:0] left_in, right_in;
    logic [1:0] left_health, right_health;
    logic [5:0] left_cmd, right_cmd;
    logic       step, round_rst;
    logic [2:0] state;
    logic [1:0] left_wins, right_wins, winner;
    logic [5:0] timer;

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];

    match_controller dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick),
        .left_in(left_in), .right_in(right_in),
        .left_health(left_health), .right_health(right_health),
        .left_cmd(left_cmd), .right_cmd(right_cmd),
        .step(step), .round_rst(round_rst), .state(state),
        .left_wins(left_wins), .right_wins(right_wins),
        .timer(timer), .winner(winner)
    );

    always #5 clk = ~clk;

    // Every step must match the oldest expected command pair.
    always @(negedge clk) begin
        if (step === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL step_unexpected: got cmd %b/%b, expected no step", left_cmd, right_cmd);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({left_cmd, right_cmd} !== e) begin
                    n_err++;
                    $display("FAIL step_cmd: got %b/%b, expected %b/%b", left_cmd, right_cmd, e[11:6], e[5:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tick = 1'b0;
        left_in = 6'd0; right_in = 6'd0;
        left_health = THREE; right_health = THREE;
        cyc(); cyc();
        rst = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d, expected 0", state); end
        n_cmp++; if ({left_cmd, right_cmd} !== {ACT_WAIT, ACT_WAIT}) begin n_err++; $display("FAIL reset_cmd: got %b/%b, expected 001000/001000", left_cmd, right_cmd); end
        n_cmp++; if ({step, round_rst} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b, expected 00", {step, round_rst}); end
        n_cmp++; if ({left_wins, right_wins, winner, timer} !== 12'd0) begin n_err++; $display("FAIL reset_counters: got %h, expected 0", {left_wins, right_wins, winner, timer}); end
    endtask

    task automatic test_start_countdown();
        start = 1'b1; tick = 1'b1; cyc();
        start = 1'b0; tick = 1'b0;
        n_cmp++; if (state !== 3'd1 || round_rst !== 1'b1) begin n_err++; $display("FAIL start_countdown: got state %0d rst %b, expected 1 1", state, round_rst); end
        cyc();
        n_cmp++; if (round_rst !== 1'b0) begin n_err++; $display("FAIL round_rst_pulse: got %b, expected 0", round_rst); end
        pulse_tick(2);
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL countdown_hold: got %0d, expected 1", state); end
        pulse_tick(1);
        n_cmp++; if (state !== 3'd2 || timer !== 6'd30) begin n_err++; $display("FAIL enter_fight: got state %0d timer %0d, expected 2 30", state, timer); end
    endtask

    task automatic test_action_sampling();
        left_in = ACT_KICK; cyc();
        left_in = 6'b000011; cyc();
        left_in = 6'd0; right_in = ACT_PUNCH; cyc();
        right_in = 6'd0;
        exp_q.push_back({ACT_KICK, ACT_PUNCH});
        tick = 1'b1; cyc(); tick = 1'b0;
        n_cmp++; if (step !== 1'b1 || left_cmd !== ACT_KICK) begin n_err++; $display("FAIL step_after_tick: got step %b cmd %b, expected 1 000010", step, left_cmd); end
        cyc();
        n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL step_once: got %b, expected 0", step); end
        exp_q.push_back({ACT_WAIT, ACT_WAIT});
        left_in = ACT_JUMP; tick = 1'b1; cyc();
        left_in = 6'd0; tick = 1'b0; cyc();
        exp_q.push_back({ACT_JUMP, ACT_WAIT});
        pulse_tick(1);
    endtask

    task automatic test_ko_round();
        right_health = ZERO; cyc();
        right_health = THREE;
        n_cmp++; if (state !== 3'd3 || left_wins !== 2'd1 || right_wins !== 2'd0) begin n_err++; $display("FAIL ko_round: got state %0d wins %0d/%0d, expected 3 1/0", state, left_wins, right_wins); end
        start = 1'b1; tick = 1'b1; cyc(); start = 1'b0; tick = 1'b0; cyc();
        n_cmp++; if (state !== 3'd3 || left_wins !== 2'd1) begin n_err++; $display("FAIL round_end_hold: got state %0d wins %0d, expected 3 1", state, left_wins); end
        tick = 1'b1; cyc(); tick = 1'b0;
        n_cmp++; if (state !== 3'd1 || round_rst !== 1'b1) begin n_err++; $display("FAIL round_end_exit: got state %0d rst %b, expected 1 1", state, round_rst); end
        cyc();
        pulse_tick(3);
    endtask

    task automatic test_match_over();
        start = 1'b1; cyc(); start = 1'b0;
        n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL start_in_fight: got %0d, expected 2", state); end
        right_health = ZERO; cyc(); right_health = THREE;
        n_cmp++; if (left_wins !== 2'd2) begin n_err++; $display("FAIL second_win: got %0d, expected 2", left_wins); end
        pulse_tick(2);
        n_cmp++; if (state !== 3'd4 || winner !== WIN_LEFT || round_rst !== 1'b0) begin n_err++; $display("FAIL match_over: got state %0d winner %b rst %b, expected 4 01 0", state, winner, round_rst); end
        pulse_tick(1);
        n_cmp++; if (state !== 3'd4 || left_wins !== 2'd2 || winner !== WIN_LEFT) begin n_err++; $display("FAIL match_over_hold: got state %0d wins %0d winner %b, expected 4 2 01", state, left_wins, winner); end
    endtask

    task automatic test_draw();
        start = 1'b1; cyc(); start = 1'b0; cyc();
        n_cmp++; if ({left_wins, right_wins, winner, timer} !== 12'd0 || state !== 3'd1) begin n_err++; $display("FAIL restart_clear: got state %0d vals %h, expected 1 0", state, {left_wins, right_wins, winner, timer}); end
        pulse_tick(3);
        left_health = ZERO; right_health = ZERO; cyc();
        left_health = THREE; right_health = THREE;
        n_cmp++; if (state !== 3'd3 || left_wins !== 2'd0 || right_wins !== 2'd0) begin n_err++; $display("FAIL draw_round: got state %0d wins %0d/%0d, expected 3 0/0", state, left_wins, right_wins); end
        pulse_tick(2);
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL draw_next_round: got %0d, expected 1", state); end
    endtask

    task automatic test_reset_mid_round();
        pulse_tick(3);
        left_in = ACT_PUNCH; cyc(); left_in = 6'd0;
        rst = 1'b1; tick = 1'b1; cyc();
        rst = 1'b0; tick = 1'b0;
        n_cmp++; if (step !== 1'b0 || state !== 3'd0 || left_cmd !== ACT_WAIT) begin n_err++; $display("FAIL reset_mid_round: got step %b state %0d cmd %b, expected 0 0 001000", step, state, left_cmd); end
    endtask

    task automatic test_timeout();
        start = 1'b1; cyc(); start = 1'b0;
        pulse_tick(3);
        left_health = TWO; right_health = ONE;
        for (int i = 0; i < 30; i++) begin
            exp_q.push_back({ACT_WAIT, ACT_WAIT});
            pulse_tick(1);
            if (i == 0) begin
                n_cmp++;
`ifdef ROUND_TIMEOUT_EN
                if (timer !== 6'd29) begin n_err++; $display("FAIL timer_dec: got %0d, expected 29", timer); end
`else
                if (timer !== 6'd30) begin n_err++; $display("FAIL timer_held: got %0d, expected 30", timer); end
`endif
            end
        end
        cyc();
        n_cmp++;
`ifdef ROUND_TIMEOUT_EN
        if (state !== 3'd3 || left_wins !== 2'd1 || right_wins !== 2'd0) begin n_err++; $display("FAIL timeout_round: got state %0d wins %0d/%0d, expected 3 1/0", state, left_wins, right_wins); end
`else
        if (state !== 3'd2 || left_wins !== 2'd0) begin n_err++; $display("FAIL no_timeout: got state %0d wins %0d, expected 2 0", state, left_wins); end
`endif
        left_health = THREE; right_health = THREE;
    endtask

    initial begin
        test_reset();
        test_start_countdown();
        test_action_sampling();
        test_ko_round();
        test_match_over();
        test_draw();
        test_reset_mid_round();
        test_timeout();
        cyc(); cyc();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL steps_missing: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter COUNTDOWN_TICKS, default 3: ticks spent in COUNTDOWN before each round.
REQ-002 Parameter ROUND_TICKS, default 30 (max 63): round length in ticks.
REQ-003 Parameter WINS_TO_MATCH, default 2 (1..3): round wins that end the match.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level; begins a match from IDLE or MATCH_OVER.
REQ-007 tick  in  1  one-cycle game-step pulse.
REQ-008 left_in / right_in  in  6 each  raw one-hot actions: GO_RIGHT 100000, GO_LEFT 010000, WAIT 001000, JUMP 000100, KICK 000010, PUNCH 000001.
REQ-009 left_health / right_health  in  2 each  health reported by the player datapaths.
REQ-010 left_cmd / right_cmd  out  6 each  registered action issued to the player datapaths.
REQ-011 step  out  1  one-cycle strobe; player datapaths apply the cmd values on this cycle.
REQ-012 round_rst  out  1  one-cycle pulse; restores player location and health.
REQ-013 state  out  3  IDLE 0, COUNTDOWN 1, FIGHT 2, ROUND_END 3, MATCH_OVER 4.
REQ-014 left_wins / right_wins  out  2 each; timer  out  6; winner  out  2 (00 none, 01 left, 10 right, 11 draw).

Function
REQ-015 Action sampling: in FIGHT, each cycle, a per-player hold register captures the input if it is exactly one-hot; zero or multi-bit inputs leave the hold register unchanged.
REQ-016 On a FIGHT tick: cmd <= hold, step = 1 on the next cycle, hold <= WAIT; cmd = WAIT outside FIGHT.
REQ-017 An input arriving in the same cycle as a tick is captured for the following step, not the current one.
REQ-018 IDLE: start -> COUNTDOWN; wins, winner and timer clear; round_rst pulses.
REQ-019 COUNTDOWN: counts COUNTDOWN_TICKS ticks, then -> FIGHT with timer = ROUND_TICKS.
REQ-020 FIGHT KO check: runs every cycle in which step = 0; a health value of 0 -> ROUND_END.
REQ-021 Round result on KO: one side at 0 -> the other side wins; both sides at 0 in the same cycle -> draw, and no win is credited.
REQ-022 ROUND_END: the winner's wins counter increments once, on entry, saturating at 3; the controller holds 2 ticks.
REQ-023 Leaving ROUND_END: if either wins counter equals WINS_TO_MATCH -> MATCH_OVER with winner set; otherwise round_rst pulses and the next state is COUNTDOWN.
REQ-024 MATCH_OVER: outputs hold; start -> COUNTDOWN as in REQ-018.
REQ-025 start is ignored in COUNTDOWN, FIGHT and ROUND_END.
REQ-026 A tick and a start in the same cycle in IDLE: start wins and the tick is dropped.

Reset
REQ-027 rst forces: state IDLE, cmd = WAIT, hold = WAIT, step 0, round_rst 0, wins 0, timer 0, winner 00.
REQ-028 Reset in mid-round discards any pending step; no step is issued on the cycle after reset.

Configuration
REQ-029 Macro ROUND_TIMEOUT_EN defined: timer decrements on each FIGHT tick.
REQ-030 With ROUND_TIMEOUT_EN, timer reaching 0 -> ROUND_END; higher health wins, equal health is a draw.
REQ-031 With ROUND_TIMEOUT_EN, KO takes priority over timeout in the same cycle.
REQ-032 Macro undefined: timer is held at ROUND_TICKS and rounds end on KO only.

Structure
REQ-033 Shared package game_pkg holds the action encodings, the health/location constants ZERO..THREE, the state encoding and the winner codes.
REQ-034 One sub-module, action_sampler (the hold register plus one-hot check), is instantiated once per player.

Verification
REQ-035 rst, then start, then 3 ticks -> state = FIGHT and timer = 30.
REQ-036 In FIGHT: left_in = KICK, then left_in = 000011, then tick -> left_cmd = 000010 and step pulses once, one cycle after the tick.
REQ-037 right_health -> 0 -> ROUND_END and left_wins = 1; after 2 ticks -> round_rst pulse, then COUNTDOWN.
REQ-038 Left wins two rounds -> MATCH_OVER with winner = 01; a start in FIGHT is ignored.
REQ-039 Both healths -> 0 in the same cycle -> draw round with both wins counters unchanged.
REQ-040 ROUND_TIMEOUT_EN defined, 30 ticks, healths 2 vs 1 -> left wins the round; ROUND_TIMEOUT_EN undefined, same stimulus -> still FIGHT.
